// File: rtl/mul_seq_ctrl_if.sv
// Start/done handshake and operand/result bus between the ALU op decoder and
// the sequential multiplier.
interface mul_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic                 add_sel;
    logic [2*WIDTH-1:0]   product;

    // start is sampled only in IDLE; done is a one-cycle pulse; product holds
    // from done until the next accepted start.
    modport master (
        output start, a, b,
        input  busy, done, add_sel, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, add_sel, product
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Unsigned shift-add multiplier: one shared WIDTH-bit adder, WIDTH RUN cycles
// per operation, sequenced by a three-state FSM.
module mul_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    mul_seq_ctrl_if.slave    bus,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_product;
    logic [WIDTH:0]       w_sum;
    logic                 w_last;

    // Upper half plus optional multiplicand; the extra bit keeps the carry.
    assign w_sum  = {1'b0, r_product[2*WIDTH-1:WIDTH]}
                  + (r_product[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:                 w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mcand   <= bus.a;
                        r_product <= {{WIDTH{1'b0}}, bus.b};
                        r_cnt     <= '0;
                    end
                end
                S_RUN: begin
                    r_product <= {w_sum, r_product[WIDTH-1:1]};
                    r_cnt     <= r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = (r_state == S_DONE);
    assign bus.add_sel = (r_state == S_RUN) && r_product[0];
    assign bus.product = r_product;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed and random multiply operations; expected products are queued at
// issue and checked by an independent monitor on every done pulse.
module tb_mul_seq_ctrl;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  mul_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mul_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [2*WIDTH-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int push_cnt = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%h required=0x%h", nm, act, req);
    end
  endtask

  // monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (reset) begin
      prev_done <= 1'b0;
    end else begin
      if (bus.done) begin
        done_cnt++;
        check("done_width", {63'd0, prev_done}, 64'd0);
        check("busy_in_done", {63'd0, bus.busy}, 64'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          check("product", bus.product, exp_q.pop_front());
        end
      end
      prev_done <= bus.done;
    end
  end

  // driver: one operation; poke_run pulses start at that RUN cycle,
  // poke_done raises start during the DONE cycle and leaves it high.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        input logic [63:0] iexp, input int poke_run,
                        input bit poke_done, input bit chk_no_add);
    int n;
    int run_cyc;
    bit seen_add;
    bit got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = ia;
    bus.b = ib;
    @(posedge clk);
    exp_q.push_back(iexp);
    push_cnt++;
    #1;
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    run_cyc = (dbg_state == ST_RUN) ? 1 : 0;
    seen_add = bus.add_sel;
    n = 0;
    got = 1'b0;
    while (n < WIDTH + 20 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) check("busy_rise", {63'd0, bus.busy}, 64'd1);
      if (poke_run > 0 && n == poke_run) begin
        bus.start = 1'b1;
        bus.a = 32'd7;
        bus.b = 32'd7;
      end else if (poke_run > 0 && n == poke_run + 1) begin
        bus.start = 1'b0;
      end
      if (dbg_state == ST_RUN) run_cyc++;
      if (bus.add_sel) seen_add = 1'b1;
      if (bus.done) got = 1'b1;
    end
    check("done_seen", {63'd0, got}, 64'd1);
    if (got) check("latency", 64'(n), 64'(WIDTH));
    check("run_cycles", 64'(run_cyc), 64'(WIDTH));
    if (chk_no_add) check("no_add_sel", {63'd0, seen_add}, 64'd0);
    if (poke_done) begin
      bus.start = 1'b1;
      bus.a = 32'd7;
      bus.b = 32'd7;
    end else begin
      @(negedge clk);
      check("busy_fall", {63'd0, bus.busy}, 64'd0);
      check("product_hold", bus.product, iexp);
    end
  endtask

  // driver: operation aborted by reset at a given RUN cycle
  task automatic abort_op(input logic [31:0] ia, input logic [31:0] ib, input int at);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = ia;
    bus.b = ib;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (at - 1) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_product", bus.product, 64'd0);
    check("abort_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    @(negedge clk);
    reset = 1'b0;
    repeat (WIDTH + 8) @(negedge clk);
    check("abort_idle", {63'd0, bus.busy}, 64'd0);
  endtask

  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_add_sel", {63'd0, bus.add_sel}, 64'd0);
    check("rst_product", bus.product, 64'd0);
    check("rst_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
    reset = 1'b0;

    run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 1'b0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 1'b0, 1'b0);
    run_op(32'h1234_5678, 32'h0, 64'h0, 0, 1'b0, 1'b1);
    run_op(32'h0, 32'hDEAD_BEEF, 64'h0, 0, 1'b0, 1'b0);
    run_op(32'd100, 32'd200, 64'h0000_0000_0000_4E20, 10, 1'b1, 1'b0);
    run_op(32'd7, 32'd7, 64'h0000_0000_0000_0031, 0, 1'b0, 1'b0);
    abort_op(32'h0001_0000, 32'h0001_0000, 10);
    run_op(32'd2, 32'h8000_0000, 64'h0000_0001_0000_0000, 0, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i < 4) rb = 32'h1 << i;
      run_op(ra, rb, 64'(ra) * 64'(rb), 0, 1'b0, 1'b0);
    end

    repeat (4) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(done_cnt), 64'(push_cnt));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
